// File: rtl/interp_pkg.sv
// Shared constants and helpers for the multi-channel interpolation chain.
package interp_pkg;

  localparam int L1     = 2;
  localparam int L2     = 4;
  localparam int DW_DEF = 16;

  typedef logic signed [DW_DEF-1:0] sample_t;

  function automatic int total_ratio(input int r3);
    return L1 * L2 * r3;
  endfunction

  function automatic int log2c(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/interp_ch.sv
// One channel: 2x FIR, 4x FIR, then hold (default) or linear final stage.
// Build with INTERP_LINEAR_EN defined to select the linear final stage.
module interp_ch
  import interp_pkg::*;
#(
  parameter int DW = 16,
  parameter int R3 = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en1_i,
  input  logic                 en2_i,
  input  logic signed [DW-1:0] x_i,
  input  logic [log2c(R3)-1:0] ph_i,
  output logic signed [DW-1:0] y_o
);

  localparam int LR3 = log2c(R3);
  localparam int SW  = DW + 5;

  typedef logic signed [DW-1:0] smp_t;
  typedef logic signed [SW-1:0] acc_t;

  localparam acc_t SMAX = acc_t'((2 ** (DW - 1)) - 1);
  localparam acc_t SMIN = acc_t'(-(2 ** (DW - 1)));

  function automatic smp_t rnd_sat(input acc_t v, input int sh);
    acc_t r;
    r = (v + (acc_t'(1) <<< (sh - 1))) >>> sh;
    if (r > SMAX) r = SMAX;
    if (r < SMIN) r = SMIN;
    return smp_t'(r);
  endfunction

  // Stage 1: 2x triangular FIR [1 2 1]/2 on the zero-stuffed input
  smp_t x1_q [2];
  smp_t s1_q;
  acc_t s1_sum;

  always_comb s1_sum = acc_t'(x_i) + (acc_t'(x1_q[0]) <<< 1) + acc_t'(x1_q[1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x1_q[0] <= '0;
      x1_q[1] <= '0;
      s1_q    <= '0;
    end else if (en1_i) begin
      x1_q[0] <= x_i;
      x1_q[1] <= x1_q[0];
      s1_q    <= rnd_sat(s1_sum, 1);
    end
  end

  // Stage 2: 4x triangular FIR [1 2 3 4 3 2 1]/4
  smp_t s2_in;
  smp_t x2_q [6];
  smp_t s2_q;
  acc_t s2_sum;

  always_comb begin
    s2_in  = en1_i ? s1_q : '0;
    s2_sum = acc_t'(s2_in)
           + (acc_t'(x2_q[0]) <<< 1)
           + (acc_t'(x2_q[1]) <<< 1) + acc_t'(x2_q[1])
           + (acc_t'(x2_q[2]) <<< 2)
           + (acc_t'(x2_q[3]) <<< 1) + acc_t'(x2_q[3])
           + (acc_t'(x2_q[4]) <<< 1)
           + acc_t'(x2_q[5]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) x2_q[i] <= '0;
      s2_q <= '0;
    end else if (en2_i) begin
      x2_q[0] <= s2_in;
      for (int i = 1; i < 6; i++) x2_q[i] <= x2_q[i-1];
      s2_q <= rnd_sat(s2_sum, 2);
    end
  end

  // Final stage
`ifdef INTERP_LINEAR_EN
  localparam int PW = DW + 1 + LR3;
  typedef logic signed [PW-1:0] prd_t;

  smp_t prev_q, prev_d, next_q, next_d, y_q, y_d;
  prd_t diff, prod;

  // ph_i is the phase of the cycle being registered into y_q
  always_comb begin
    prev_d = prev_q;
    next_d = next_q;
    if (en2_i) begin
      prev_d = next_q;
      next_d = s2_q;
    end
    diff = prd_t'(next_d) - prd_t'(prev_d);
    prod = diff * prd_t'({1'b0, ph_i});
    y_d  = smp_t'(prd_t'(prev_d) + (prod >>> LR3));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= '0;
      next_q <= '0;
      y_q    <= '0;
    end else begin
      prev_q <= prev_d;
      next_q <= next_d;
      y_q    <= y_d;
    end
  end
`else
  smp_t y_q;
  logic unused_ph;

  assign unused_ph = ^ph_i;

  always_ff @(posedge clk) begin
    if (!rst_n)     y_q <= '0;
    else if (en2_i) y_q <= s2_q;
  end
`endif

  assign y_o = y_q;

endmodule

// File: rtl/interp_chain_mc.sv
// NCH-channel 8*R3 interpolation chain with a one-deep valid/ready input buffer.
// INTERP_LINEAR_EN selects the linear final stage inside interp_ch.
module interp_chain_mc
  import interp_pkg::*;
#(
  parameter int DW  = 16,
  parameter int NCH = 2,
  parameter int R3  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NCH*DW-1:0] in_data,
  input  logic              underrun_clr,
  output logic [NCH*DW-1:0] out_data,
  output logic              out_valid,
  output logic              out_strobe,
  output logic              frame_start,
  output logic              underrun
);

  localparam int TOT = total_ratio(R3);
  localparam int CW  = log2c(TOT);
  localparam int LR3 = log2c(R3);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              buf_full_q, buf_full_d;
  logic [NCH*DW-1:0] buf_q;
  logic              underrun_q, underrun_d;
  logic              out_valid_q, out_strobe_q;
  logic              en1, en2, accept;
  logic [NCH*DW-1:0] s1_vec;

  // No bypass: a vector accepted at cnt==0 waits for the next frame
  always_comb begin
    frame_start = (cnt_q == '0);
    en2         = (cnt_q[LR3-1:0] == '0);
    en1         = (cnt_q[LR3+1:0] == '0);
    in_ready    = !buf_full_q || frame_start;
    accept      = in_valid && in_ready;
    cnt_d       = (cnt_q == CW'(TOT - 1)) ? '0 : cnt_q + CW'(1);
    buf_full_d  = buf_full_q;
    if (frame_start)  buf_full_d = accept;
    else if (accept)  buf_full_d = 1'b1;
    underrun_d  = underrun_q;
    if (frame_start && !buf_full_q) underrun_d = 1'b1;
    else if (underrun_clr)          underrun_d = 1'b0;
    s1_vec      = (frame_start && buf_full_q) ? buf_q : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      buf_full_q   <= 1'b0;
      underrun_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_strobe_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      buf_full_q   <= buf_full_d;
      underrun_q   <= underrun_d;
      out_strobe_q <= en2;
      if (en2) out_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) buf_q <= in_data;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    interp_ch #(.DW(DW), .R3(R3)) u_ch (
      .clk   (clk),
      .rst_n (~rst),
      .en1_i (en1),
      .en2_i (en2),
      .x_i   (s1_vec[c*DW +: DW]),
      .ph_i  (cnt_q[LR3-1:0]),
      .y_o   (out_data[c*DW +: DW])
    );
  end

  assign out_valid  = out_valid_q;
  assign out_strobe = out_strobe_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_interp_chain_mc.sv
// Self-checking bench for interp_chain_mc: handshake/underrun model plus DC, hold and ramp properties.
module tb_interp_chain_mc;

  localparam int DW  = 16;
  localparam int NCH = 2;
  localparam int R3  = 16;
  localparam int TOT = 8 * R3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              underrun_clr = 1'b0;
  logic [NCH*DW-1:0] in_data = '0;
  logic              in_ready, out_valid, out_strobe, frame_start, underrun;
  logic [NCH*DW-1:0] out_data;

  int checks = 0;
  int errors = 0;
  int pos = 0;
  bit m_full = 1'b0;
  bit m_under = 1'b0;

  interp_chain_mc #(.DW(DW), .NCH(NCH), .R3(R3)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .underrun_clr (underrun_clr),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_strobe   (out_strobe),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Advance one clock, updating the buffer/underrun model from the spec rules.
  task automatic cycle();
    bit acc;
    acc = in_valid && (!m_full || pos == 0);
    if (rst) begin
      m_full  = 1'b0;
      m_under = 1'b0;
    end else begin
      if (pos == 0 && !m_full) m_under = 1'b1;
      else if (underrun_clr)   m_under = 1'b0;
      if (pos == 0)  m_full = acc;
      else if (acc)  m_full = 1'b1;
    end
    @(posedge clk);
    #1;
    pos = rst ? 0 : (pos + 1) % TOT;
  endtask

  task automatic go_to_pos0();
    for (int i = 0; i < TOT && pos != 0; i++) cycle();
  endtask

  function automatic int chv(input int c);
    logic signed [DW-1:0] v;
    v = out_data[c*DW +: DW];
    return int'(v);
  endfunction

  function automatic logic [NCH*DW-1:0] pack2(input int a0, input int a1);
    logic [NCH*DW-1:0] d;
    d = {DW'(a1), DW'(a0)};
    return d;
  endfunction

  task automatic test_reset();
    int n;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = (NCH*DW)'($urandom());
      cycle();
    end
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    checks++; if (out_data !== '0)     begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_strobe !== 1'b0) begin errors++; $display("FAIL reset_out_strobe got %b want 0", out_strobe); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL reset_frame_start got %b want 1", frame_start); end
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (underrun !== 1'b0)   begin errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
    cycle();
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL post_reset_frame_start got %b want 0", frame_start); end
    checks++; if (underrun !== 1'b1)   begin errors++; $display("FAIL post_reset_underrun got %b want 1", underrun); end
    n = 1;
    while (frame_start !== 1'b1 && n < 2 * TOT) begin
      cycle();
      n++;
    end
    checks++; if (n != TOT) begin errors++; $display("FAIL frame_period got %0d want %0d", n, TOT); end
    underrun_clr = 1'b1;
    cycle();
    underrun_clr = 1'b0;
    checks++; if (underrun !== m_under) begin errors++; $display("FAIL reset_clr_underrun got %b want %b", underrun, m_under); end
  endtask

  task automatic test_dc(input int a0, input int a1);
    int nacc;
    in_valid = 1'b1;
    in_data  = pack2(a0, a1);
    go_to_pos0();
    repeat (6 * TOT) cycle();
    underrun_clr = 1'b1;
    cycle();
    underrun_clr = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL dc_underrun got %b want 0", underrun); end
    nacc = 0;
    for (int i = 0; i < TOT; i++) begin
      checks++; if (chv(0) < a0 - 1 || chv(0) > a0 + 1) begin errors++; $display("FAIL dc_ch0 got %0d want %0d+-1 pos %0d", chv(0), a0, pos); end
      checks++; if (chv(1) < a1 - 1 || chv(1) > a1 + 1) begin errors++; $display("FAIL dc_ch1 got %0d want %0d+-1 pos %0d", chv(1), a1, pos); end
      checks++; if (in_ready !== (pos == 0)) begin errors++; $display("FAIL dc_in_ready got %b want %b pos %0d", in_ready, pos == 0, pos); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dc_out_valid got %b want 1", out_valid); end
      if (in_valid && in_ready) nacc++;
      cycle();
    end
    checks++; if (nacc != 1) begin errors++; $display("FAIL dc_accepts_per_frame got %0d want 1", nacc); end
  endtask

  task automatic test_underrun();
    int mode, at;
    in_valid = 1'b0;
    underrun_clr = 1'b0;
    go_to_pos0();
    for (int f = 0; f < 14; f++) begin
      mode = (f == 0) ? 0 : int'($urandom_range(0, 2));
      at   = int'($urandom_range(0, TOT - 1));
      for (int i = 0; i < TOT; i++) begin
        in_valid     = (mode == 2) || (mode == 1 && i == at);
        in_data      = (NCH*DW)'($urandom());
        underrun_clr = ($urandom_range(0, 15) == 0);
        checks++; if (in_ready !== (!m_full || pos == 0)) begin errors++; $display("FAIL ur_in_ready got %b want %b pos %0d", in_ready, (!m_full || pos == 0), pos); end
        checks++; if (underrun !== m_under) begin errors++; $display("FAIL ur_underrun got %b want %b pos %0d", underrun, m_under, pos); end
        cycle();
      end
    end
    in_valid = 1'b0;
    underrun_clr = 1'b0;
    go_to_pos0();
    for (int i = 0; i < TOT && pos != TOT - 2; i++) cycle();
    underrun_clr = 1'b1;
    cycle();
    underrun_clr = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear got %b want 0", underrun); end
    cycle();
    underrun_clr = 1'b1;
    cycle();
    underrun_clr = 1'b0;
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_set_wins got %b want 1", underrun); end
    repeat (5) cycle();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky got %b want 1", underrun); end
    underrun_clr = 1'b1;
    cycle();
    underrun_clr = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clr_pulse got %b want 0", underrun); end
  endtask

  task automatic test_same_cycle(input int a0, input int a1, input int b0, input int b1);
    in_valid = 1'b1;
    in_data  = pack2(a0, a1);
    go_to_pos0();
    repeat (6 * TOT) cycle();
    underrun_clr = 1'b1;
    cycle();
    underrun_clr = 1'b0;
    go_to_pos0();
    in_data = pack2(b0, b1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sc_ready_pos0 got %b want 1", in_ready); end
    cycle();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sc_buf_held got %b want 0", in_ready); end
    for (int i = 0; i < TOT - 1 + 4 * R3; i++) begin
      checks++; if (chv(0) < a0 - 1 || chv(0) > a0 + 1) begin errors++; $display("FAIL sc_old_ch0 got %0d want %0d pos %0d", chv(0), a0, pos); end
      checks++; if (chv(1) < a1 - 1 || chv(1) > a1 + 1) begin errors++; $display("FAIL sc_old_ch1 got %0d want %0d pos %0d", chv(1), a1, pos); end
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL sc_no_underrun got %b want 0 pos %0d", underrun, pos); end
      cycle();
    end
    go_to_pos0();
    cycle();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL sc_underrun_after got %b want 1", underrun); end
    underrun_clr = 1'b1;
    cycle();
    underrun_clr = 1'b0;
  endtask

`ifndef INTERP_LINEAR_EN
  task automatic test_hold();
    logic [NCH*DW-1:0] prev;
    in_valid = 1'b1;
    go_to_pos0();
    for (int i = 0; i < 5 * TOT; i++) begin
      if (pos == 0) in_data = (NCH*DW)'($urandom());
      prev = out_data;
      cycle();
      checks++; if (out_strobe !== (pos % R3 == 1)) begin errors++; $display("FAIL hold_strobe got %b want %b pos %0d", out_strobe, (pos % R3 == 1), pos); end
      checks++; if ((out_data !== prev) && (pos % R3 != 1)) begin errors++; $display("FAIL hold_change got %h want %h pos %0d", out_data, prev, pos); end
    end
  endtask
`else
  task automatic test_linear();
    int p0, d;
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    in_valid = 1'b1;
    underrun_clr = 1'b0;
    p0 = 0;
    for (int f = 0; f < 16; f++) begin
      in_data = pack2((f + 1) * R3 * 64, -(f + 1) * R3 * 64);
      for (int i = 0; i < TOT; i++) begin
        checks++; if (chv(1) != -chv(0)) begin errors++; $display("FAIL lin_indep got %0d want %0d", chv(1), -chv(0)); end
        d = chv(0) - p0;
        if (f >= 2) begin
          checks++; if (d < 0 || d > 9) begin errors++; $display("FAIL lin_step got %0d want 0..9 pos %0d", d, pos); end
        end
        p0 = chv(0);
        cycle();
      end
    end
    underrun_clr = 1'b1;
    cycle();
    underrun_clr = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    test_reset();
    test_dc(1000, -2000);
    test_dc(int'($urandom_range(0, 60000)) - 30000, int'($urandom_range(0, 60000)) - 30000);
    test_dc(int'($urandom_range(0, 60000)) - 30000, int'($urandom_range(0, 60000)) - 30000);
    test_underrun();
    test_same_cycle(3000, -1500, -12000, 9000);
`ifndef INTERP_LINEAR_EN
    test_hold();
`else
    test_linear();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interp_chain_mc.md
# interp_chain_mc

Multi-channel, parametrised interpolation chain: NCH channels of DW-bit samples are upsampled by 8·R3 (2× FIR → 4× FIR → R3× final stage). It sits between the loop-filter/controller output (input rate f_in) and the DAC-side datapath (clk rate = 8·R3·f_in). It replaces the fixed single-channel chain: a valid/ready input handshake replaces free-running sampling, underrun is detected, and a linear final stage can be compiled in.

## Interface
- DW, 16, sample width (signed, two's complement)
- NCH, 2, channel count
- R3, 16, final-stage ratio; power of two, ≥2
- clk  in  1  sample clock, one output sample per cycle
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample vector valid
- in_ready  out  1  block can accept a vector this cycle
- in_data  in  NCH·DW  channel c at bits [c·DW +: DW]
- underrun_clr  in  1  clears the sticky underrun flag
- out_data  out  NCH·DW  interpolated output, same packing as in_data
- out_valid  out  1  output holds a computed value
- out_strobe  out  1  1-cycle pulse when the final stage loads a new stage-2 value
- frame_start  out  1  high when cnt==0
- underrun  out  1  sticky; a frame started with no buffered input

## Operation
- Frame counter cnt runs 0..8·R3−1 and wraps to 0.
- Stage-1 enable: cnt mod 4·R3 == 0. Stage-2 enable: cnt mod R3 == 0.
- Input buffer: one vector deep, with flag buf_full.
  - in_ready = !buf_full || cnt==0.
  - A vector is accepted when in_valid && in_ready.
  - At cnt==0 the buffered vector feeds stage-1 and buf_full clears. If a new vector is accepted in the same cycle, buf_full stays set.
  - There is no bypass. A vector accepted at cnt==0 into an empty buffer is used in the next frame.
- Underrun: at cnt==0 with buf_full==0, stage-1 is fed 0 for every channel and underrun is set. underrun_clr clears it. If set and clear land in the same cycle, set wins.
- Stage-1 input: the buffered sample at cnt==0, 0 at cnt==4·R3 (zero-stuffing).
- Stage-2 input: the stage-1 output at each stage-1 enable, 0 at the other stage-2 enables.
- fir_stage1 and fir_stage2 coefficient sums are 2 and 4, so the chain DC gain is 1.
- Final stage (default, zero-order hold): hold_c loads the stage-2 output at each stage-2 enable; out_data = hold_c.
- All channels are processed identically and in lockstep. Channels never interact.
- out_valid rises on the first stage-2 enable after reset and stays high until the next reset.

## Timing
- Reset values: cnt=0, buf_full=0, in_ready=1 (cnt==0), out_data=0, out_valid=0, out_strobe=0, frame_start=1, underrun=0. All FIR state is cleared (FIR rst_n driven by ~rst).
- out_strobe and the hold register update occur in the cycle after each stage-2 enable; out_data is registered.
- Latency from the accepting frame_start to the first out_strobe reflecting the sample: one stage-1 period plus one stage-2 period plus 1 cycle, i.e. 4·R3 + R3 + 1 cycles, plus the FIR group delay.
- Reset mid-frame restarts at cnt=0 and discards the buffered vector; underrun is not set by the reset itself.

## Configuration
- INTERP_LINEAR_EN defined: the final stage is linear.
  - Keep prev_c and next_c, both loaded at the stage-2 update.
  - phase = (cnt − 1) mod R3.
  - out = prev_c + ((next_c − prev_c)·phase) >>> log2(R3).
  - The difference is DW+1 bits and the product DW+1+log2(R3) bits, with an arithmetic shift. The result always lies between prev and next, so it is truncated to DW without saturation.
  - One stage-2 period of extra latency.
- INTERP_LINEAR_EN undefined: zero-order hold as above, and no prev/next/multiplier logic is generated.

## Structure
- Package interp_pkg holds:
  - L1=2 and L2=4;
  - the total-ratio function 8·R3;
  - a log2 constant function;
  - the signed sample typedef parameterised on DW.
- Sub-module interp_ch holds one channel: fir_stage1, fir_stage2 and the final stage.
- The top level owns cnt, the enables, the input buffer/handshake and the flags, and generates NCH interp_ch instances.

## Test plan
- Reset: assert rst for 3 cycles mid-frame → all outputs at their reset values; cnt==0 on the first cycle after release.
- DC: in_valid held high, ch0=1000, ch1=−2000 → after settling, out_data ch0=1000±1 and ch1=−2000±1, constant over 8·R3 cycles. Exactly one vector accepted per frame; in_ready low from the cycle after acceptance until cnt==0.
- Underrun: skip one frame's input → underrun=1 at that frame_start and stays sticky; underrun_clr pulse → 0; set and clear in the same cycle → remains 1.
- Same-cycle accept and consume at cnt==0 with buf_full=1 → the old vector is used, the new one is held, buf_full stays 1.
- Hold mode: out_data changes only in the cycle after cnt mod R3==0; out_strobe pulses there once per R3 cycles.
- INTERP_LINEAR_EN, ramp input +R3·64 per frame: every output step ≤ the stage-2 delta/R3 + 1 and is monotonic; ch0 and ch1 are independent under opposite ramps.
